// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_pkg
// Purpose  : Shared default depths for the synchronizer blocks.
// Revision : 1.0
// ============================================================================
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int RST_STAGES_DEF  = 2;

endpackage
`default_nettype wire

// File: rtl/synchronizer_if.sv
`default_nettype none
// ============================================================================
// Module   : synchronizer_if
// Purpose  : Raw-pin input and synchronized outputs of the synchronizer.
// Revision : 1.0
// ============================================================================
interface synchronizer_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] first_out;

  modport master (output in, input out, input first_out);
  modport slave  (input in, output out, output first_out);

endinterface
`default_nettype wire

// File: rtl/reset_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : reset_synchronizer
// Purpose  : Async-assert / sync-release reset chain producing rst_n_sync.
// Revision : 1.0
// ============================================================================
module reset_synchronizer
  import sync_pkg::*;
#(
  parameter int RST_STAGES = RST_STAGES_DEF
) (
  input  wire  clk,
  input  wire  reset,
  output logic rst_n_sync
);

  if (RST_STAGES < 2) begin : g_bad_depth
    $fatal(1, "reset_synchronizer: RST_STAGES must be >= 2");
  end

  (* ASYNC_REG = "TRUE", preserve *) logic [RST_STAGES-1:0] r_chain;

  // Constant 1 walks in after release; a low raw reset wipes it instantly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[RST_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = r_chain[RST_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : synchronizer
// Purpose  : Multi-stage per-bit input synchronizer with internal reset sync.
// Revision : 1.0
// ============================================================================
module synchronizer
  import sync_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int STAGES     = SYNC_STAGES_DEF,
  parameter int RST_STAGES = RST_STAGES_DEF
) (
  input  wire           clk,
  input  wire           reset,
  synchronizer_if.slave bus
);

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "synchronizer: STAGES must be >= 2");
  end

  logic             rst_n_sync;
  logic [WIDTH-1:0] w_stage [STAGES];

  reset_synchronizer #(
    .RST_STAGES (RST_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .reset      (reset),
    .rst_n_sync (rst_n_sync)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    (* ASYNC_REG = "TRUE", preserve *) logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;

    if (k == 0) begin : g_head
      assign w_d = bus.in;
    end else begin : g_tail
      assign w_d = w_stage[k-1];
    end

    // Each bit is an independent flop; no cross-bit coherency is implied.
    always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
        r_q <= '0;
      end else begin
        r_q <= w_d;
      end
    end

    assign w_stage[k] = r_q;
  end

  assign bus.first_out = w_stage[0];
  assign bus.out       = w_stage[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_synchronizer.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_synchronizer
// Purpose  : Directed self-checking bench for a 1-bit/2-stage and 4-bit/3-stage synchronizer.
// Revision : 1.0
// ============================================================================
module tb_synchronizer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  synchronizer_if #(.WIDTH(1)) b1 ();
  synchronizer_if #(.WIDTH(4)) b4 ();

  synchronizer #(.WIDTH(1), .STAGES(2), .RST_STAGES(2)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  synchronizer #(.WIDTH(4), .STAGES(3), .RST_STAGES(2)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic fo, input logic o);
    check_eq({tag, ".first_out"}, 32'(b1.first_out), 32'(fo));
    check_eq({tag, ".out"},       32'(b1.out),       32'(o));
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    b1.in  = 1'b0;
    b4.in  = 4'h0;

    // Power-on
    #1;
    chk1("por_t1", 1'b0, 1'b0);
    check_eq("por_rst_n_sync_low", 32'(u_dut1.rst_n_sync), 32'd0);
    check_eq("por_w4_out", 32'(b4.out), 32'h0);
    check_eq("por_w4_first", 32'(b4.first_out), 32'h0);
    #4 reset = 1'b1;                       // release at 5 ns, mid-cycle
    tick();                                // edge 1
    check_eq("por_rst_n_sync_e1", 32'(u_dut1.rst_n_sync), 32'd0);
    chk1("por_e1", 1'b0, 1'b0);
    tick();                                // edge 2
    check_eq("por_rst_n_sync_e2", 32'(u_dut1.rst_n_sync), 32'd1);
    chk1("por_e2", 1'b0, 1'b0);

    // Single-cycle pulse
    b1.in = 1'b1;
    tick();
    chk1("pulse_e1", 1'b1, 1'b0);
    b1.in = 1'b0;
    tick();
    chk1("pulse_e2", 1'b0, 1'b1);
    tick();
    chk1("pulse_e3", 1'b0, 1'b0);

    // Mid-cycle change, 7 ns past an edge
    #6 b1.in = 1'b1;
    tick();
    chk1("mid_e1", 1'b1, 1'b0);
    tick();
    chk1("mid_e2", 1'b1, 1'b1);
    b1.in = 1'b0;
    tick();
    chk1("mid_e3", 1'b0, 1'b1);
    tick();
    chk1("mid_e4", 1'b0, 1'b0);

    // Mid-operation reset with in=1 held
    b1.in = 1'b1;
    b4.in = 4'hF;
    tick();
    tick();
    tick();
    chk1("mrst_pre", 1'b1, 1'b1);
    check_eq("mrst_pre_w4", 32'(b4.out), 32'hF);
    reset = 1'b0;
    #0.5;
    chk1("mrst_clear", 1'b0, 1'b0);
    check_eq("mrst_clear_w4", 32'(b4.out), 32'h0);
    check_eq("mrst_clear_w4_first", 32'(b4.first_out), 32'h0);
    #3.5 reset = 1'b1;
    tick();
    chk1("mrst_e1", 1'b0, 1'b0);
    tick();
    check_eq("mrst_rst_n_sync_e2", 32'(u_dut1.rst_n_sync), 32'd1);
    chk1("mrst_e2", 1'b0, 1'b0);
    tick();
    chk1("mrst_e3", 1'b1, 1'b0);
    tick();
    chk1("mrst_e4", 1'b1, 1'b1);

    // Reset glitch: 3 ns low pulse between edges
    #2 reset = 1'b0;
    #1;
    chk1("glitch_clear", 1'b0, 1'b0);
    check_eq("glitch_clear_w4", 32'(b4.out), 32'h0);
    #2 reset = 1'b1;
    tick();
    chk1("glitch_e1", 1'b0, 1'b0);
    tick();
    chk1("glitch_e2", 1'b0, 1'b0);
    tick();
    chk1("glitch_e3", 1'b1, 1'b0);
    tick();
    chk1("glitch_e4", 1'b1, 1'b1);

    // WIDTH=4, STAGES=3 latency
    b4.in = 4'h0;
    tick();
    tick();
    tick();
    check_eq("w4_idle", 32'(b4.out), 32'h0);
    b4.in = 4'hA;
    tick();
    check_eq("w4_e1_first", 32'(b4.first_out), 32'hA);
    check_eq("w4_e1_out", 32'(b4.out), 32'h0);
    b4.in = 4'h5;
    tick();
    check_eq("w4_e2_first", 32'(b4.first_out), 32'h5);
    check_eq("w4_e2_out", 32'(b4.out), 32'h0);
    tick();
    check_eq("w4_e3_out", 32'(b4.out), 32'hA);
    tick();
    check_eq("w4_e4_out", 32'(b4.out), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
